// File: rtl/ipd_feeder.sv
// ipd_feeder: instruction feeder placed in front of the decode stage.
//
// Holds a loadable program memory. A start pulse in IDLE launches a run that
// issues (instruction, pc) pairs over a valid/rdy handshake until count_in
// words have been accepted. A watchdog aborts the run if decode stalls for
// MAX_STALL consecutive cycles.
//
// Ports:
//   clk_in, reset_in        clock, synchronous active-high reset
//   start_in, start_pc_in   start pulse (IDLE only) and first pc
//   count_in                number of words to issue
//   pm_wr_in/waddr/wdata    program memory write port (ignored during FEED)
//   instr_out, pc_out       registered word and its pc
//   valid_out, rdy_in       handshake towards decode
//   busy_out                high while feeding
//   done_out                one-cycle pulse on normal completion
//   timeout_out             sticky stall-timeout flag
//   issued_out              saturating count of accepted transfers
//
// Optional build macro FEED_STOP_ON_EBREAK_EN: when defined, an accepted
// EBREAK word (32'h0010_0073) ends the run as if it were the last one.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for start; memory writable
// FEED  | presenting words to decode, counting stalls
// DONE  | run completed; done_out pulses on the next cycle
// TOUT  | watchdog fired; timeout_out latches on the next cycle

module ipd_feeder #(
    parameter int unsigned     I_SZ      = 32,
    parameter int unsigned     PC_SZ     = 32,
    parameter int unsigned     PML       = 512,
    parameter int unsigned     PC_INC    = 1,
    parameter int unsigned     CNT_SZ    = 16,
    parameter int unsigned     MAX_STALL = 100,
    parameter logic [I_SZ-1:0] NOP_WORD  = I_SZ'(32'h0000_0013),
    localparam int unsigned    AW        = $clog2(PML)
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              start_in,
    input  logic [PC_SZ-1:0]  start_pc_in,
    input  logic [CNT_SZ-1:0] count_in,
    input  logic              pm_wr_in,
    input  logic [AW-1:0]     pm_waddr_in,
    input  logic [I_SZ-1:0]   pm_wdata_in,
    output logic [I_SZ-1:0]   instr_out,
    output logic [PC_SZ-1:0]  pc_out,
    output logic              valid_out,
    input  logic              rdy_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              timeout_out,
    output logic [CNT_SZ-1:0] issued_out
);

    localparam int unsigned    SW       = $clog2(MAX_STALL + 1);
    localparam logic [PC_SZ:0] PML_W    = (PC_SZ + 1)'(PML);
    localparam logic [I_SZ-1:0] EBREAK  = I_SZ'(32'h0010_0073);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FEED = 2'd1,
        S_DONE = 2'd2,
        S_TOUT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_SZ-1:0]  pc_q, pc_d;
    logic [I_SZ-1:0]   instr_q, instr_d;
    logic [CNT_SZ-1:0] rem_q, rem_d;
    logic [CNT_SZ-1:0] issued_q, issued_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;

    logic [I_SZ-1:0]   pm [PML];

    logic              start_ok;
    logic              xfer;
    logic              last_xfer;
    logic              stall_hit;
    logic              pm_we;
    logic [PC_SZ-1:0]  nxt_pc;
    logic              nxt_in_range;
    logic [I_SZ-1:0]   rd_word;

    assign start_ok  = (state_q == S_IDLE) && start_in;
    assign xfer      = (state_q == S_FEED) && rdy_in;
    assign stall_hit = (state_q == S_FEED) && !rdy_in && (stall_q == SW'(MAX_STALL - 1));
    assign pm_we     = pm_wr_in && (state_q != S_FEED);

`ifdef FEED_STOP_ON_EBREAK_EN
    assign last_xfer = (rem_q == CNT_SZ'(1)) || (instr_q == EBREAK);
`else
    assign last_xfer = (rem_q == CNT_SZ'(1));
`endif

    // Address of the word that will be presented next: the following pc
    // during a run, otherwise the start pc of a run about to begin.
    assign nxt_pc       = (state_q == S_FEED) ? pc_q + PC_SZ'(PC_INC) : start_pc_in;
    assign nxt_in_range = {1'b0, nxt_pc} < PML_W;

    // A write landing in the same cycle as the start is forwarded so the
    // first issued word already carries the new data.
    always_comb begin
        rd_word = NOP_WORD;
        if (nxt_in_range) begin
            if (pm_we && (pm_waddr_in == nxt_pc[AW-1:0])) begin
                rd_word = pm_wdata_in;
            end else begin
                rd_word = pm[nxt_pc[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (pm_we) begin
            pm[pm_waddr_in] <= pm_wdata_in;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            rem_q     <= '0;
            issued_q  <= '0;
            stall_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            rem_q     <= rem_d;
            issued_q  <= issued_d;
            stall_q   <= stall_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (count_in != '0) ? S_FEED : S_DONE;
                end
            end
            S_FEED: begin
                if (xfer) begin
                    if (last_xfer) begin
                        state_d = S_DONE;
                    end
                end else if (stall_hit) begin
                    state_d = S_TOUT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_TOUT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        rem_d     = rem_q;
        issued_d  = issued_q;
        stall_d   = stall_q;
        valid_d   = (state_d == S_FEED);
        done_d    = (state_q == S_DONE);
        timeout_d = timeout_q || (state_q == S_TOUT);

        if (start_ok) begin
            pc_d      = nxt_pc;
            instr_d   = rd_word;
            rem_d     = count_in;
            issued_d  = '0;
            stall_d   = '0;
            timeout_d = 1'b0;
        end else if (xfer) begin
            pc_d     = nxt_pc;
            instr_d  = rd_word;
            rem_d    = rem_q - CNT_SZ'(1);
            issued_d = (issued_q == {CNT_SZ{1'b1}}) ? issued_q : issued_q + CNT_SZ'(1);
            stall_d  = '0;
        end else if (state_q == S_FEED) begin
            stall_d = stall_q + SW'(1);
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign valid_out   = valid_q;
    assign busy_out    = (state_q == S_FEED);
    assign done_out    = done_q;
    assign timeout_out = timeout_q;
    assign issued_out  = issued_q;

endmodule

// File: tb/tb_ipd_feeder.sv
module tb_ipd_feeder;

    localparam int unsigned PML       = 512;
    localparam int unsigned PC_INC    = 1;
    localparam int unsigned MAX_STALL = 100;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] EBRK      = 32'h0010_0073;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        start_in = 1'b0;
    logic [31:0] start_pc_in = '0;
    logic [15:0] count_in = '0;
    logic        pm_wr_in = 1'b0;
    logic [8:0]  pm_waddr_in = '0;
    logic [31:0] pm_wdata_in = '0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        rdy_in = 1'b0;
    logic        busy_out;
    logic        done_out;
    logic        timeout_out;
    logic [15:0] issued_out;

    ipd_feeder dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .start_in    (start_in),
        .start_pc_in (start_pc_in),
        .count_in    (count_in),
        .pm_wr_in    (pm_wr_in),
        .pm_waddr_in (pm_waddr_in),
        .pm_wdata_in (pm_wdata_in),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out),
        .rdy_in      (rdy_in),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .timeout_out (timeout_out),
        .issued_out  (issued_out)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_err = 0;

    // Reference copy of the program memory, updated only by accepted writes.
    logic [31:0] mem_m [PML];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return (pc < PML) ? mem_m[pc[8:0]] : NOP;
    endfunction

    task automatic wr(input int a, input logic [31:0] d);
        pm_wr_in    = 1'b1;
        pm_waddr_in = 9'(a);
        pm_wdata_in = d;
        mem_m[a]    = d;
        step();
        pm_wr_in = 1'b0;
    endtask

    // mode: 0 rdy always, 1 random rdy, 2 rdy pattern 1,0,0, 3 rdy for the
    // first n_ok transfers and then never again.
    task automatic run(input logic [31:0] spc, input int cnt, input int mode,
                       input int n_ok, input bit wr_start);
        int n_exp, n_xf, k, streak, ndone, done_cyc, last_x, nvalid, cyc;
        bit tout_exp;
        logic [31:0] pc_e;
        if (wr_start) begin
            pm_wr_in    = 1'b1;
            pm_waddr_in = spc[8:0];
            pm_wdata_in = $urandom;
            mem_m[spc[8:0]] = pm_wdata_in;
        end
        n_exp = cnt;
`ifdef FEED_STOP_ON_EBREAK_EN
        for (int i = 0; i < cnt; i++) begin
            if (exp_word(spc + 32'(i * PC_INC)) == EBRK) begin
                n_exp = i + 1;
                break;
            end
        end
`endif
        tout_exp = (mode == 3) && (n_ok < n_exp);
        n_xf     = tout_exp ? n_ok : n_exp;

        start_in    = 1'b1;
        start_pc_in = spc;
        count_in    = 16'(cnt);
        step();
        start_in = 1'b0;
        pm_wr_in = 1'b0;
        chk("start_tout", {63'd0, timeout_out}, 64'd0);
        chk("start_issued", {48'd0, issued_out}, 64'd0);
        chk("start_valid", {63'd0, valid_out}, {63'd0, cnt != 0});

        k = 0; streak = 0; ndone = 0; done_cyc = -1; last_x = -1; nvalid = 0;
        for (cyc = 0; cyc < 1000; cyc++) begin
            if (done_out) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (valid_out) begin
                nvalid++;
                pc_e = spc + 32'(k * PC_INC);
                chk("pc", {32'd0, pc_out}, {32'd0, pc_e});
                chk("instr", {32'd0, instr_out}, {32'd0, exp_word(pc_e)});
                chk("issued_run", {48'd0, issued_out}, 64'(k));
                case (mode)
                    0:       rdy_in = 1'b1;
                    1:       rdy_in = 1'($urandom_range(0, 1));
                    2:       rdy_in = (cyc % 3 == 0);
                    default: rdy_in = (k < n_ok);
                endcase
                if (rdy_in) begin
                    streak = 0;
                    k++;
                    last_x = cyc;
                end else begin
                    streak++;
                end
                // Writes during a run must be ignored; the model does not see them.
                pm_wr_in    = ($urandom_range(0, 3) == 0);
                pm_waddr_in = 9'($urandom);
                pm_wdata_in = $urandom;
            end else begin
                rdy_in   = 1'($urandom_range(0, 1));
                pm_wr_in = 1'b0;
                if (done_cyc >= 0 && cyc == done_cyc + 1) break;
                if (timeout_out) break;
            end
            step();
        end
        pm_wr_in = 1'b0;
        rdy_in   = 1'b0;

        chk("budget", {63'd0, cyc < 1000}, 64'd1);
        chk("xfers", 64'(k), 64'(n_xf));
        chk("issued_end", {48'd0, issued_out}, 64'(n_xf));
        chk("tout_flag", {63'd0, timeout_out}, {63'd0, tout_exp});
        chk("valid_idle", {63'd0, valid_out}, 64'd0);
        chk("busy_idle", {63'd0, busy_out}, 64'd0);
        if (tout_exp) begin
            chk("tout_no_done", 64'(ndone), 64'd0);
            chk("stall_len", 64'(streak), 64'(MAX_STALL));
        end else begin
            chk("done_count", 64'(ndone), 64'd1);
            chk("done_lat", 64'(done_cyc - last_x), 64'd2);
        end
        if (cnt == 0) chk("zero_no_valid", 64'(nvalid), 64'd0);
    endtask

    initial begin
        logic [31:0] spc;
        int sel;

        repeat (3) step();
        chk("rst_valid", {63'd0, valid_out}, 64'd0);
        chk("rst_busy", {63'd0, busy_out}, 64'd0);
        chk("rst_done", {63'd0, done_out}, 64'd0);
        chk("rst_tout", {63'd0, timeout_out}, 64'd0);
        chk("rst_issued", {48'd0, issued_out}, 64'd0);
        chk("rst_instr", {32'd0, instr_out}, 64'd0);
        chk("rst_pc", {32'd0, pc_out}, 64'd0);
        reset_in = 1'b0;

        for (int a = 0; a < int'(PML); a++) wr(a, $urandom);
        wr(0, 32'h0050_0093);
        wr(1, 32'h00A0_0113);
        wr(2, 32'h0020_81B3);
        wr(3, 32'h4020_8233);
        wr(4, 32'h0020_F2B3);

        run(32'd0, 5, 0, 0, 1'b0);
        run(32'd0, 5, 2, 0, 1'b0);
        run(32'd510, 4, 1, 0, 1'b0);
        run(32'd0, 5, 3, 0, 1'b0);
        run(32'd0, 5, 3, 2, 1'b0);
        run(32'd0, 0, 0, 0, 1'b0);
        run(32'd7, 3, 0, 0, 1'b1);
        run(32'hFFFF_FFFE, 4, 1, 0, 1'b0);

        // Reset in the middle of a run.
        start_in    = 1'b1;
        start_pc_in = 32'd0;
        count_in    = 16'd5;
        rdy_in      = 1'b1;
        step();
        start_in = 1'b0;
        step();
        step();
        chk("mid_issued2", {48'd0, issued_out}, 64'd2);
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        rdy_in   = 1'b0;
        chk("mid_rst_valid", {63'd0, valid_out}, 64'd0);
        chk("mid_rst_issued", {48'd0, issued_out}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy_out}, 64'd0);
        sel = 0;
        repeat (5) begin
            step();
            if (done_out) sel++;
        end
        chk("mid_rst_no_done", 64'(sel), 64'd0);

        // EBREAK in the program: stops early only with the feature built in.
        wr(2, EBRK);
        run(32'd0, 10, 0, 0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       spc = 32'($urandom_range(0, 40));
                1:       spc = 32'($urandom_range(500, 520));
                2:       spc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                default: spc = 32'($urandom_range(0, 511));
            endcase
            run(spc, int'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 0,
                1'($urandom_range(0, 1)));
        end
        run(32'd20, 6, 3, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ipd_feeder.md
Name: ipd_feeder

Overview:
- Parametrised, synthesizable instruction feeder that replaces ad-hoc bench loops driving the decode stage.
- Holds a loadable program memory. On a start pulse it issues (instruction, pc) pairs over a valid/rdy handshake until a programmed count is reached.
- Tracks transfers, detects handshake stalls with a watchdog, and reports done/timeout status.
- Sits directly in front of decode, in benches and in FPGA bring-up builds.

Parameters:
- I_SZ, 32, instruction width.
- PC_SZ, 32, program counter width.
- PML, 512, program memory depth in words; AW = clog2(PML).
- PC_INC, 1, pc increment per transfer.
- CNT_SZ, 16, width of count_in and issued_out.
- MAX_STALL, 100, consecutive stalled cycles before timeout.
- NOP_WORD, 32'h0000_0013, instruction returned for out-of-range pc.

Ports:
- clk_in  in  1  system clock
- reset_in  in  1  synchronous reset, active-high
- start_in  in  1  start pulse; honoured only in IDLE
- start_pc_in  in  PC_SZ  first pc to issue
- count_in  in  CNT_SZ  number of instructions to issue
- pm_wr_in  in  1  program memory write strobe
- pm_waddr_in  in  AW  write address
- pm_wdata_in  in  I_SZ  write data
- instr_out  out  I_SZ  instruction to decode
- pc_out  out  PC_SZ  pc of instr_out
- valid_out  out  1  instr_out/pc_out valid
- rdy_in  in  1  decode ready
- busy_out  out  1  high in FEED
- done_out  out  1  one-cycle pulse on normal completion
- timeout_out  out  1  sticky stall-timeout flag
- issued_out  out  CNT_SZ  transfers completed since last start

Behaviour:
- Reset (synchronous, clk_in rising edge with reset_in=1):
  - State goes to IDLE.
  - valid_out, busy_out, done_out, timeout_out = 0; issued_out = 0; instr_out = 0; pc_out = 0.
  - Program memory contents are not cleared.
  - Reset mid-FEED aborts immediately; no done pulse is generated.
- States: IDLE, FEED, DONE, TOUT.
- IDLE:
  - start_in=1 with count_in>0: load pc = start_pc_in, remaining = count_in; clear issued_out and timeout_out; go to FEED. valid_out rises the next cycle, carrying pm[start_pc_in].
  - start_in=1 with count_in=0: clear issued_out and timeout_out; go to DONE. No valid is ever asserted.
- Memory read:
  - instr_out = pm[pc] when pc < PML, else NOP_WORD.
  - pc_out = pc.
  - Outputs are registered and change only on a transfer or a state entry.
- FEED:
  - valid_out = 1. A transfer is valid_out & rdy_in on the clock edge.
  - On each transfer: pc += PC_INC (wraps modulo 2^PC_SZ), remaining -= 1, issued_out += 1, and the next word is presented the following cycle. Back-to-back transfers run at 1 per cycle.
  - Transfer with remaining = 1: go to DONE; valid_out = 0 the next cycle.
  - While valid_out & !rdy_in, instr_out and pc_out are held stable.
- Watchdog:
  - Stall counter increments on each FEED cycle with rdy_in=0 and clears on any transfer.
  - When it reaches MAX_STALL, go to TOUT and drop valid_out.
  - If a transfer and the MAX_STALL threshold coincide, the transfer wins.
- DONE: done_out = 1 for exactly one cycle, then IDLE.
- TOUT: timeout_out = 1 (sticky), then IDLE. timeout_out clears on reset or on the next accepted start.
- start_in in FEED, DONE or TOUT is ignored.
- Program memory writes:
  - Accepted in IDLE, DONE and TOUT; ignored in FEED.
  - A write and a start in the same cycle: the write completes first, so the first issued word sees the new data.
- issued_out saturates at 2^CNT_SZ-1.

Optional Feature:
- Macro FEED_STOP_ON_EBREAK_EN.
- Defined: a transfer whose instr_out == 32'h0010_0073 (EBREAK) ends the run as though remaining were 1. State goes to DONE with a done pulse; issued_out includes the EBREAK.
- Undefined: EBREAK is issued like any other word and only count_in ends the run.

Test Plan:
- Load pm[0..4] = 0x00500093, 0x00A00113, 0x002081B3, 0x40208233, 0x0020F2B3; start_pc=0, count=5, rdy_in=1 -> five consecutive transfers with pc 0..4, then done_out pulse; issued_out=5.
- Same program with rdy_in toggling 1,0,0,1,... -> instr_out/pc_out held during stalls; identical 5-word sequence; done after the 5th transfer.
- start_pc=510, count=4, PML=512 -> pc 510, 511 carry pm data; pc 512, 513 carry 0x00000013.
- rdy_in=0 for 100 cycles in FEED -> valid_out drops; timeout_out=1; no done; issued_out unchanged; next start clears timeout_out.
- count=0 start -> done pulse 2 cycles later; valid_out never high. Reset asserted mid-run after 2 transfers -> valid_out=0 next cycle and issued_out=0.
- With FEED_STOP_ON_EBREAK_EN, pm[2]=0x00100073 and count=10 -> 3 transfers, done pulse, issued_out=3.
